reg_file_sb: RTL and testbench

//   Parametrised ARM-core register file with an integrated pending-write scoreboard.

---
 rtl/reg_file_sb_if.sv | 38 +++
 rtl/reg_file_sb.sv | 114 +++++++++++
 tb/tb_reg_file_sb.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_sb_if.sv
// Register-file/scoreboard bus: two read ports, issue and write-back.
// master drives indices, strobes and WB data; slave returns data and status.
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] src1;
  logic [ADDR_W-1:0] src2;
  logic              src1_used;
  logic              src2_used;
  logic              issue_en;
  logic [ADDR_W-1:0] issue_dest;
  logic [ADDR_W-1:0] Dest_wb;
  logic [DATA_W-1:0] Result_WB;
  logic              writeBackEn;
  logic [DATA_W-1:0] reg1;
  logic [DATA_W-1:0] reg2;
  logic              busy1;
  logic              busy2;
  logic              hazard;
  logic [ADDR_W:0]   pending_cnt;

  modport master (
    output src1, src2, src1_used, src2_used,
    output issue_en, issue_dest,
    output Dest_wb, Result_WB, writeBackEn,
    input  reg1, reg2, busy1, busy2,
    input  hazard, pending_cnt
  );

  modport slave (
    input  src1, src2, src1_used, src2_used,
    input  issue_en, issue_dest,
    input  Dest_wb, Result_WB, writeBackEn,
    output reg1, reg2, busy1, busy2,
    output hazard, pending_cnt
  );
endinterface

// File: rtl/reg_file_sb.sv
// ID-stage register file with pending-write scoreboard and RAW hazard flag.
// Ports: clk, rst (sync, active-low), bus (reg_file_sb_if.slave).
// Define REGFILE_BYPASS_EN for same-cycle WB-to-read forwarding.
module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 15
) (
  input logic          clk,
  input logic          rst,
  reg_file_sb_if.slave bus
);

  logic [DATA_W-1:0] data [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_nxt;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_nxt;
  logic [DATA_W-1:0] rd1, rd2;
  logic              pb1, pb2;
  logic              busy1, busy2;

  // Indices >= DEPTH never match, so they read 0 / not busy.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    pb1 = 1'b0;
    pb2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.src1 == ADDR_W'(i)) begin
        rd1 = data[i];
        pb1 = pend[i];
      end
      if (bus.src2 == ADDR_W'(i)) begin
        rd2 = data[i];
        pb2 = pend[i];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

  function automatic logic in_rng(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_V;
  endfunction

  logic fwd1, fwd2;

  always_comb begin
    fwd1 = bus.writeBackEn && bus.Dest_wb == bus.src1
           && in_rng(bus.src1);
    fwd2 = bus.writeBackEn && bus.Dest_wb == bus.src2
           && in_rng(bus.src2);
  end

  // A same-cycle issue to the forwarded register is a newer
  // producer, so the register stays busy.
  assign bus.reg1 = fwd1 ? bus.Result_WB : rd1;
  assign bus.reg2 = fwd2 ? bus.Result_WB : rd2;
  assign busy1 = fwd1
    ? (bus.issue_en && bus.issue_dest == bus.src1) : pb1;
  assign busy2 = fwd2
    ? (bus.issue_en && bus.issue_dest == bus.src2) : pb2;
`else
  assign bus.reg1 = rd1;
  assign bus.reg2 = rd2;
  assign busy1    = pb1;
  assign busy2    = pb2;
`endif

  assign bus.busy1  = busy1;
  assign bus.busy2  = busy2;
  assign bus.hazard = (bus.src1_used & busy1)
                    | (bus.src2_used & busy2);
  assign bus.pending_cnt = cnt;

  // Set beats clear: an issue in the WB cycle is the newer producer.
  always_comb begin
    pend_nxt = pend;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.issue_en && bus.issue_dest == ADDR_W'(i))
        pend_nxt[i] = 1'b1;
      else if (bus.writeBackEn && bus.Dest_wb == ADDR_W'(i))
        pend_nxt[i] = 1'b0;
    end
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++)
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(pend_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pend <= '0;
      cnt  <= '0;
    end else begin
      pend <= pend_nxt;
      cnt  <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst)
        data[i] <= DATA_W'(i);
      else if (bus.writeBackEn && bus.Dest_wb == ADDR_W'(i))
        data[i] <= bus.Result_WB;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomized + directed bench for reg_file_sb against an array model.
// Build with or without REGFILE_BYPASS_EN to match the DUT.
module tb_reg_file_sb;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int N  = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_file_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] m_data [N];
  bit            m_pend [N];
  bit            m_valid = 1'b0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += m_pend[i];
    return c;
  endfunction

  // Expected read data / busy for one port, from model + current inputs.
  task automatic m_port(input int s,
                        output logic [DW-1:0] d,
                        output bit b);
    int wd = int'(bus.Dest_wb);
    int id = int'(bus.issue_dest);
    d = '0;
    b = 1'b0;
    if (s < N) begin
      d = m_data[s];
      b = m_pend[s];
`ifdef REGFILE_BYPASS_EN
      if (bus.writeBackEn && wd == s) begin
        d = bus.Result_WB;
        b = bus.issue_en && id == s;
      end
`endif
    end
  endtask

  task automatic drive(input bit r,
                       input int s1, input int s2,
                       input bit u1, input bit u2,
                       input bit ie, input int id,
                       input bit we, input int wd,
                       input logic [DW-1:0] wr);
    rst             = r;
    bus.src1        = AW'(s1);
    bus.src2        = AW'(s2);
    bus.src1_used   = u1;
    bus.src2_used   = u2;
    bus.issue_en    = ie;
    bus.issue_dest  = AW'(id);
    bus.writeBackEn = we;
    bus.Dest_wb     = AW'(wd);
    bus.Result_WB   = wr;
  endtask

  // Called at a negedge with inputs driven: compare, clock, update model.
  task automatic tick();
    logic [DW-1:0] d1, d2;
    bit b1, b2;
    #1;
    if (m_valid) begin
      m_port(int'(bus.src1), d1, b1);
      m_port(int'(bus.src2), d2, b2);
      check("reg1", bus.reg1, d1);
      check("reg2", bus.reg2, d2);
      check("busy1", bus.busy1, b1);
      check("busy2", bus.busy2, b2);
      check("hazard", bus.hazard,
            (bus.src1_used & b1) | (bus.src2_used & b2));
      check("pending_cnt", bus.pending_cnt, m_count());
    end
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        m_data[i] = DW'(i);
        m_pend[i] = 1'b0;
      end
      m_valid = 1'b1;
    end else begin
      if (bus.writeBackEn && int'(bus.Dest_wb) < N) begin
        m_data[int'(bus.Dest_wb)] = bus.Result_WB;
        m_pend[int'(bus.Dest_wb)] = 1'b0;
      end
      if (bus.issue_en && int'(bus.issue_dest) < N)
        m_pend[int'(bus.issue_dest)] = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, '0);
    tick();

    // reset values
    drive(1, 3, 14, 0, 0, 0, 0, 0, 0, '0);
    #1;
    check("t1_reg1", bus.reg1, 3);
    check("t1_reg2", bus.reg2, 14);
    check("t1_busy", {bus.busy1, bus.busy2}, 0);
    check("t1_cnt", bus.pending_cnt, 0);
    tick();

    // write then read
    drive(1, 0, 0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF);
    tick();
    drive(1, 5, 0, 0, 0, 0, 0, 0, 0, '0);
    #1 check("t2_reg1", bus.reg1, 32'hDEADBEEF);
    tick();

    // issue, hazard, write-back clears
    drive(1, 0, 0, 0, 0, 1, 7, 0, 0, '0);
    tick();
    drive(1, 0, 7, 0, 1, 0, 0, 0, 0, '0);
    #1;
    check("t3_busy2", bus.busy2, 1);
    check("t3_haz", bus.hazard, 1);
    check("t3_cnt", bus.pending_cnt, 1);
    tick();
    drive(1, 0, 7, 0, 1, 0, 0, 1, 7, 32'h77);
`ifdef REGFILE_BYPASS_EN
    #1 check("t3_wb_busy2", bus.busy2, 0);
`else
    #1 check("t3_wb_busy2", bus.busy2, 1);
`endif
    tick();
    drive(1, 0, 7, 0, 1, 0, 0, 0, 0, '0);
    #1;
    check("t3_busy2_clr", bus.busy2, 0);
    check("t3_haz_clr", bus.hazard, 0);
    check("t3_cnt_clr", bus.pending_cnt, 0);
    check("t3_reg2", bus.reg2, 32'h77);
    tick();

    // same-cycle issue + WB: stays pending
    drive(1, 0, 0, 0, 0, 1, 4, 0, 0, '0);
    tick();
    drive(1, 0, 0, 0, 0, 1, 4, 1, 4, 32'h55);
    tick();
    drive(1, 4, 0, 1, 0, 0, 0, 0, 0, '0);
    #1;
    check("t4_busy1", bus.busy1, 1);
    check("t4_reg1", bus.reg1, 32'h55);
    check("t4_cnt", bus.pending_cnt, 1);
    tick();

    // out-of-range write-back
    drive(1, 0, 0, 0, 0, 0, 0, 1, 15, 32'h1234);
    tick();
    drive(1, 15, 4, 0, 0, 0, 0, 0, 0, '0);
    #1;
    check("t5_reg1", bus.reg1, 0);
    check("t5_busy1", bus.busy1, 0);
    check("t5_reg2", bus.reg2, 32'h55);
    check("t5_cnt", bus.pending_cnt, 1);
    tick();

    // WB and read same cycle
    drive(1, 2, 0, 1, 0, 0, 0, 1, 2, 32'hA5);
    #1;
`ifdef REGFILE_BYPASS_EN
    check("t6_reg1", bus.reg1, 32'hA5);
`else
    check("t6_reg1", bus.reg1, 2);
`endif
    check("t6_busy1", bus.busy1, 0);
    tick();

    // random traffic, occasional mid-run reset
    for (int k = 0; k < 600; k++) begin
      drive($urandom_range(0, 49) != 0,
            $urandom_range(0, 15), $urandom_range(0, 15),
            1'($urandom), 1'($urandom),
            $urandom_range(0, 2) == 0, $urandom_range(0, 15),
            $urandom_range(0, 2) == 0, $urandom_range(0, 15),
            $urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
